fmt_pkt_sink: RTL
=================

// Module: fmt_pkt_sink
// PURPOSE
// Downstream responder for the formatter packet interface. Arbitrates fmt_req by
// issuing a one-cycle fmt_grant only when buffer space covers fmt_length. Receives
// start/data/end beats and stores them in an internal FIFO. Drains complete
// packets only, on a valid/ready word stream with chid and last tags.
// Flags any formatter protocol violation and discards the offending packet.
// PARAMETERS
// DEPTH  64  FIFO capacity in 32-bit words; power of two, >= 32
// PORTS
// clk         in   1   clock, all logic on posedge
// rstn        in   1   synchronous active-low reset
// fmt_req     in   1   formatter requests to send a packet
// fmt_chid    in   2   packet channel id, valid while fmt_req=1
// fmt_length  in   5   packet length in words, valid while fmt_req=1
// fmt_grant   out  1   one-cycle grant pulse
// fmt_start   in   1   first data beat marker
// fmt_end     in   1   last data beat marker
// fmt_data    in   32  data beat
// out_valid   out  1   committed word available
// out_ready   in   1   consumer accepts word when out_valid & out_ready
// out_data    out  32  word
// out_chid    out  2   channel id of word's packet
// out_last    out  1   word is last of packet
// err_proto   out  1   one-cycle pulse on protocol violation
// pkt_cnt     out  16  committed packets, wraps at 2^16
// drop_cnt    out  8   discarded packets, saturates at 255
// BEHAVIOUR
// Reset (rstn=0 at posedge) clears all outputs, state, pointers and counters to 0.
// Reset mid-packet drops all stored data, including committed words.
// Storage: FIFO entry {last,chid,data}, 35 bits.
// Pointers wr_ptr, cmt_ptr and rd_ptr are each clog2(DEPTH)+1 bits.
// free = DEPTH-(wr_ptr-rd_ptr); out_valid = (rd_ptr != cmt_ptr).
// Output is fall-through: out_* show the entry at rd_ptr; rd_ptr++ on out_valid&out_ready.
// FSM IDLE -> GRANT -> FIRST -> BODY -> IDLE:
//  IDLE: if fmt_req & fmt_length!=0 & free>=fmt_length, latch chid/len, go GRANT.
//   Else stay; no error for insufficient space.
//   fmt_req with fmt_length==0: err_proto pulse, drop_cnt++, stay IDLE, no grant.
//  GRANT: fmt_grant=1 (registered, exactly this cycle), go FIRST.
//  FIRST: fmt_start must be 1 and fmt_req must be 0; else error, go IDLE, nothing written.
//   Valid start: write beat 1, beat=1.
//   If len==1, fmt_end must be 1: commit, go IDLE; else error.
//   If len>1 and fmt_end=1: error.
//   Otherwise go BODY.
//  BODY: each cycle writes one beat and increments beat.
//   fmt_start=1 is an error.
//   fmt_end must be 1 exactly when beat reaches len; else error.
//   fmt_end at beat==len: write the beat with last=1, cmt_ptr<=wr_ptr+1, pkt_cnt++, go IDLE.
//  Any error: err_proto pulse next cycle, wr_ptr rolled back to cmt_ptr, drop_cnt++, go IDLE.
// Latency: fmt_req seen -> fmt_grant 1 cycle later.
//  Last beat -> out_valid no earlier than 1 cycle later.
// Reader and writer run concurrently. A read in the commit cycle is legal.
// Space is reserved at grant, so a granted packet never overflows.
// fmt_chid/fmt_length changes after grant are ignored; latched values rule.
// Back-to-back: new grant possible in the cycle after the commit cycle (IDLE re-evaluates).
// TESTING
// 1) DEPTH=64, req chid=2 len=4, data 1..4, out_ready=1 -> grant 1 cycle after req;
//    out words 1..4, chid=2, last on 4th only; pkt_cnt=1.
// 2) len=1 with start=end=1 -> one word with last=1; err_proto stays 0.
// 3) Fill 40 words with out_ready=0, then req len=31 (free=24) -> no grant;
//    drain 7 words -> grant issued next cycle.
// 4) len=5 with end on beat 3 -> err_proto pulse, drop_cnt=1, out_valid stays 0,
//    next good packet output intact.
// 5) grant issued but start=0 in FIRST -> err_proto, IDLE, wr_ptr unchanged;
//    fmt_length=0 req -> err_proto, no grant.
// 6) rstn=0 during BODY with 2 committed words -> after reset out_valid=0,
//    fmt_grant=0, counters 0; next packet accepted normally.

Source files
------------

// File: rtl/fmt_pkt_sink.sv
// Formatter packet sink: grants on free space, buffers beats, and releases
// only fully committed packets on a valid/ready word stream.
module fmt_pkt_sink #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fmt_req,
  input  logic [1:0]  fmt_chid,
  input  logic [4:0]  fmt_length,
  output logic        fmt_grant,
  input  logic        fmt_start,
  input  logic        fmt_end,
  input  logic [31:0] fmt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_chid,
  output logic        out_last,
  output logic        err_proto,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_FIRST,
    S_BODY
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]     chid_q, chid_d;
  logic [4:0]     len_q, len_d;
  logic [4:0]     beat_q, beat_d;
  logic           grant_q, grant_d;
  logic           err_q, err_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic [34:0]    mem_q [DEPTH];
  logic [34:0]    rd_word;
  logic [PW-1:0]  used;
  logic [PW-1:0]  free;
  logic [4:0]     beat_nx;
  logic           rd_fire;
  logic           wr_en;
  logic           wr_last;
  logic           commit;
  logic           proto_err;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign free      = PW'(DEPTH) - used;
  assign beat_nx   = beat_q + 5'd1;
  assign out_valid = (rd_ptr_q != cmt_ptr_q);
  assign rd_fire   = out_valid & out_ready;
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];

  // Hide stale RAM contents so every output reads 0 when nothing is valid.
  assign out_data  = out_valid ? rd_word[31:0]  : '0;
  assign out_chid  = out_valid ? rd_word[33:32] : '0;
  assign out_last  = out_valid & rd_word[34];
  assign fmt_grant = grant_q;
  assign err_proto = err_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cmt_ptr_d  = cmt_ptr_q;
    rd_ptr_d   = rd_ptr_q + PW'(rd_fire);
    chid_d     = chid_q;
    len_d      = len_q;
    beat_d     = beat_q;
    grant_d    = 1'b0;
    err_d      = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    commit     = 1'b0;
    proto_err  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fmt_req) begin
          if (fmt_length == 5'd0) begin
            proto_err = 1'b1;
          end else if (free >= PW'(fmt_length)) begin
            chid_d  = fmt_chid;
            len_d   = fmt_length;
            grant_d = 1'b1;
            state_d = S_GRANT;
          end
        end
      end
      S_GRANT: begin
        state_d = S_FIRST;
      end
      S_FIRST: begin
        if (!fmt_start || fmt_req) begin
          proto_err = 1'b1;
        end else if (len_q == 5'd1) begin
          if (fmt_end) commit = 1'b1;
          else         proto_err = 1'b1;
        end else if (fmt_end) begin
          proto_err = 1'b1;
        end else begin
          wr_en   = 1'b1;
          beat_d  = 5'd1;
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (fmt_start) begin
          proto_err = 1'b1;
        end else if (fmt_end != (beat_nx == len_q)) begin
          proto_err = 1'b1;
        end else begin
          wr_en  = 1'b1;
          beat_d = beat_nx;
          commit = fmt_end;
        end
      end
    endcase

    if (wr_en || commit) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (commit) begin
      wr_last   = 1'b1;
      cmt_ptr_d = wr_ptr_q + PW'(1);
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      state_d   = S_IDLE;
    end
    // Uncommitted beats vanish by pulling the write pointer back.
    if (proto_err) begin
      err_d    = 1'b1;
      wr_ptr_d = cmt_ptr_q;
      state_d  = S_IDLE;
      if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      chid_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      grant_q    <= 1'b0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      chid_q     <= chid_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en || commit) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, chid_q, fmt_data};
    end
  end

endmodule
